// File: rtl/if_pkg.sv
// Shared fetch-path types and constants for the IF/ID buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_pkg;

  localparam int PC_W   = 6;
  localparam int INST_W = 32;

  // Value driven onto the decode instruction bus when no entry is valid.
  localparam logic [INST_W-1:0] NOP_INST = '0;

  // One fetched instruction paired with the PC it was read from.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with registered storage and a synchronous clear.
// Latency: push visible at the head one cycle after the push edge.
// Backpressure: push is ignored when full (unless popping), pop is ignored when empty.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset (also zeroes storage)
//   clear         synchronous flush of pointers and count, priority over push/pop
//   push/push_dat write one entry
//   pop           retire the head entry
//   head_dat      current head entry (meaningful only while count != 0)
//   count         occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop & (count != '0);
  assign do_push  = push & ((count < CW'(DEPTH)) | do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/if_id_buf.sv
// Fetch-to-decode buffer: pairs each issued PC with the ROM word returned a cycle later and queues it.
// Latency: issue to id_valid is 2 cycles (one in the request register, one in the FIFO).
// Backpressure: stall_req holds the PC register whenever queued plus in-flight entries reach DEPTH.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   if_pc, if_ce    PC presented to the ROM and its fetch enable
//   rom_inst        ROM data, belongs to the PC presented one cycle earlier
//   stall_req       hold the PC (registered-only, no input-to-output path)
//   flush           drop all queued and in-flight fetches
//   id_valid/id_ready, id_pc, id_inst  decode-side handshake; data masked to 0 when empty
module if_id_buf #(
  parameter int PC_W   = if_pkg::PC_W,
  parameter int INST_W = if_pkg::INST_W,
  parameter int DEPTH  = 4              // power of 2, at least 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   if_pc,
  input  logic              if_ce,
  input  logic [INST_W-1:0] rom_inst,
  output logic              stall_req,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [PC_W-1:0]   id_pc,
  output logic [INST_W-1:0] id_inst
);

  import if_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic          req_vld;
  logic [PC_W-1:0] req_pc;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          issue;
  logic          pop;
  entry_t        push_dat;
  entry_t        head_dat;

  // Counting the in-flight fetch as occupied guarantees a slot exists for
  // it when its ROM word arrives, so a full FIFO never drops a capture.
  assign occ       = {1'b0, count} + {{CW{1'b0}}, req_vld};
  assign stall_req = occ >= (CW+1)'(DEPTH);

  // A held PC with if_ce=1 keeps re-reading the ROM; gating issue with
  // stall_req is what stops those re-reads from becoming duplicates.
  assign issue = if_ce & ~stall_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_vld <= 1'b0;
      req_pc  <= '0;
    end else if (flush) begin
      req_vld <= 1'b0;
    end else begin
      req_vld <= issue;
      req_pc  <= if_pc;
    end
  end

  // The ROM word on this cycle's bus belongs to last cycle's PC.
  assign push_dat.pc   = req_pc;
  assign push_dat.inst = rom_inst;

  assign id_valid = (count != '0);
  assign pop      = id_valid & id_ready;
  assign id_pc    = id_valid ? head_dat.pc   : '0;
  assign id_inst  = id_valid ? head_dat.inst : INST_W'(NOP_INST);

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .push     (req_vld),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (count)
  );

endmodule
